// File: rtl/apb_master.sv
// APB3 requester: registers one valid/ready request, runs SETUP/ACCESS on the
// APB bus with a bounded pready wait, and returns done/read data/error status.
module apb_master #(
  parameter int unsigned addr_width     = 32,
  parameter int unsigned data_width     = 32,
  parameter int unsigned timeout_cycles = 16
) (
  input  logic                  i_clk_apb,
  input  logic                  i_rstn_apb,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [addr_width-1:0] i_addr,
  input  logic                  i_rd0_wr1,
  input  logic [data_width-1:0] i_wr_data,
  output logic                  o_done,
  output logic                  o_rd_valid,
  output logic [data_width-1:0] o_rd_data,
  output logic                  o_err,
  output logic                  o_timeout,
  output logic                  o_psel,
  output logic                  o_penable,
  output logic                  o_pwrite,
  output logic [addr_width-1:0] o_paddr,
  output logic [data_width-1:0] o_pwdata,
  input  logic [data_width-1:0] i_prdata,
  input  logic                  i_pready,
  input  logic                  i_pslverr
);

  // Handshake: a request transfers on a clock edge where i_valid=1 and
  // o_ready=1; the requester must hold i_valid and its payload until then.

  localparam int unsigned CW    = (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
  localparam int unsigned TLAST = (timeout_cycles == 0) ? 0 : timeout_cycles - 1;
  localparam logic [CW-1:0] CNT_LAST = TLAST[CW-1:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [data_width-1:0] rd_data_q, rd_data_d;
  logic                  err_q, err_d;
  logic                  timeout_q, timeout_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [addr_width-1:0] paddr_q, paddr_d;
  logic [data_width-1:0] pwdata_q, pwdata_d;

  always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
    if (!i_rstn_apb) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    err_d      = 1'b0;
    timeout_d  = 1'b0;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (i_valid && ready_q) begin
          paddr_d  = i_addr;
          pwrite_d = i_rd0_wr1;
          pwdata_d = i_wr_data;
          psel_d   = 1'b1;
          ready_d  = 1'b0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready beats a coinciding timeout edge.
        if (i_pready || (timeout_cycles != 0 && cnt_q == CNT_LAST)) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
          err_d     = i_pready ? i_pslverr : 1'b1;
          timeout_d = ~i_pready;
          if (!pwrite_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = i_pready ? i_prdata : '0;
          end
        end else if (timeout_cycles != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready    = ready_q;
  assign o_done     = done_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_err      = err_q;
  assign o_timeout  = timeout_q;
  assign o_psel     = psel_q;
  assign o_penable  = penable_q;
  assign o_pwrite   = pwrite_q;
  assign o_paddr    = paddr_q;
  assign o_pwdata   = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (timeout_cycles=4): zero-wait, wait states,
// slave error, timeout, back-to-back and mid-transfer reset.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] addr = '0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic        done, rd_valid, err, tmo;
  logic [31:0] rd_data;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  apb_master #(.addr_width(32), .data_width(32), .timeout_cycles(4)) dut (
    .i_clk_apb(clk), .i_rstn_apb(rstn),
    .i_valid(valid), .o_ready(ready), .i_addr(addr), .i_rd0_wr1(wr),
    .i_wr_data(wdata), .o_done(done), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .o_err(err), .o_timeout(tmo), .o_psel(psel), .o_penable(penable),
    .o_pwrite(pwrite), .o_paddr(paddr), .o_pwdata(pwdata),
    .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {ready, done, rd_valid, err, timeout, psel, penable, pwrite}
  function automatic logic [7:0] flags();
    return {ready, done, rd_valid, err, tmo, psel, penable, pwrite};
  endfunction

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1; wr = w; addr = a; wdata = d;
  endtask

  initial begin
    // Reset
    #12;
    chk("reset_flags", {56'd0, flags()}, 64'h0);
    chk("reset_paddr", {32'd0, paddr}, 64'h0);
    chk("reset_rd_data", {32'd0, rd_data}, 64'h0);
    rstn = 1'b1;
    chk("ready_before_edge", {63'd0, ready}, 64'd0);
    tick();
    chk("ready_after_edge", {63'd0, ready}, 64'd1);

    // Zero-wait write
    req(1'b1, 32'h10, 32'hDEAD_BEEF); pready = 1'b1;
    tick(); valid = 1'b0;
    chk("wr0_setup", {56'd0, flags()}, {56'd0, 8'b0000_0101});
    chk("wr0_paddr", {32'd0, paddr}, 64'h10);
    chk("wr0_pwdata", {32'd0, pwdata}, 64'hDEAD_BEEF);
    tick();
    chk("wr0_access", {56'd0, flags()}, {56'd0, 8'b0000_0111});
    tick();
    chk("wr0_done", {56'd0, flags()}, {56'd0, 8'b1100_0001});
    tick();
    chk("wr0_idle", {56'd0, flags()}, {56'd0, 8'b1000_0001});

    // Read with two wait states
    req(1'b0, 32'h24, 32'h0); pready = 1'b0;
    tick(); valid = 1'b0;
    chk("rd2_setup", {56'd0, flags()}, {56'd0, 8'b0000_0100});
    tick();
    chk("rd2_access1", {56'd0, flags()}, {56'd0, 8'b0000_0110});
    tick();
    chk("rd2_access2", {56'd0, flags()}, {56'd0, 8'b0000_0110});
    chk("rd2_paddr_w1", {32'd0, paddr}, 64'h24);
    tick();
    chk("rd2_access3", {56'd0, flags()}, {56'd0, 8'b0000_0110});
    chk("rd2_paddr_w2", {32'd0, paddr}, 64'h24);
    pready = 1'b1; prdata = 32'h1234_5678;
    tick(); pready = 1'b0; prdata = 32'h0;
    chk("rd2_done", {56'd0, flags()}, {56'd0, 8'b1110_0000});
    chk("rd2_rd_data", {32'd0, rd_data}, 64'h1234_5678);

    // Slave error on write
    req(1'b1, 32'h30, 32'h55); pready = 1'b1; pslverr = 1'b1;
    tick(); valid = 1'b0;
    tick();
    tick();
    chk("slverr_done", {56'd0, flags()}, {56'd0, 8'b1101_0001});
    pslverr = 1'b0;
    tick();
    chk("slverr_clear", {56'd0, flags()}, {56'd0, 8'b1000_0001});
    chk("rd_data_hold", {32'd0, rd_data}, 64'h1234_5678);

    // Timeout on read
    req(1'b0, 32'h40, 32'h0); pready = 1'b0; prdata = 32'hFFFF_FFFF;
    tick(); valid = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("tmo_wait%0d", i), {56'd0, flags()}, {56'd0, 8'b0000_0110});
    end
    tick();
    chk("tmo_done", {56'd0, flags()}, {56'd0, 8'b1111_1000});
    chk("tmo_rd_data", {32'd0, rd_data}, 64'h0);
    tick();
    chk("tmo_pulse_end", {56'd0, flags()}, {56'd0, 8'b1000_0000});

    // pready on the 4th ACCESS edge wins
    req(1'b0, 32'h44, 32'h0);
    tick(); valid = 1'b0;
    tick();
    tick(); tick(); tick();
    chk("race_wait3", {56'd0, flags()}, {56'd0, 8'b0000_0110});
    pready = 1'b1; prdata = 32'h0000_A5A5;
    tick(); pready = 1'b0;
    chk("race_done", {56'd0, flags()}, {56'd0, 8'b1110_0000});
    chk("race_rd_data", {32'd0, rd_data}, 64'hA5A5);

    // Back-to-back: write 0x4 then read 0x8, valid held
    req(1'b1, 32'h4, 32'h11); pready = 1'b1;
    tick();
    chk("b2b_setup1", {56'd0, flags()}, {56'd0, 8'b0000_0101});
    req(1'b0, 32'h8, 32'h0); prdata = 32'hCAFE_0008;
    tick();
    chk("b2b_access1", {56'd0, flags()}, {56'd0, 8'b0000_0111});
    chk("b2b_paddr1", {32'd0, paddr}, 64'h4);
    tick();
    chk("b2b_done1", {56'd0, flags()}, {56'd0, 8'b1100_0001});
    tick(); valid = 1'b0;
    chk("b2b_setup2", {56'd0, flags()}, {56'd0, 8'b0000_0100});
    chk("b2b_paddr2", {32'd0, paddr}, 64'h8);
    tick();
    chk("b2b_access2", {56'd0, flags()}, {56'd0, 8'b0000_0110});
    tick();
    chk("b2b_done2", {56'd0, flags()}, {56'd0, 8'b1110_0000});
    chk("b2b_rd_data", {32'd0, rd_data}, 64'hCAFE_0008);

    // Reset during ACCESS
    req(1'b1, 32'h50, 32'h99); pready = 1'b0;
    tick(); valid = 1'b0;
    tick();
    chk("rst_pre_access", {56'd0, flags()}, {56'd0, 8'b0000_0111});
    rstn = 1'b0;
    #1;
    chk("rst_async_flags", {56'd0, flags()}, 64'h0);
    chk("rst_async_paddr", {32'd0, paddr}, 64'h0);
    chk("rst_async_pwdata", {32'd0, pwdata}, 64'h0);
    chk("rst_async_rd_data", {32'd0, rd_data}, 64'h0);
    tick();
    chk("rst_no_done", {56'd0, flags()}, 64'h0);
    rstn = 1'b1;
    chk("rst_ready_low", {63'd0, ready}, 64'd0);
    tick();
    chk("rst_ready_high", {63'd0, ready}, 64'd1);
    req(1'b1, 32'h60, 32'h77); pready = 1'b1;
    tick(); valid = 1'b0;
    chk("post_rst_setup", {56'd0, flags()}, {56'd0, 8'b0000_0101});
    tick();
    tick();
    chk("post_rst_done", {56'd0, flags()}, {56'd0, 8'b1100_0001});
    chk("post_rst_pwdata", {32'd0, pwdata}, 64'h77);
    chk("post_rst_paddr", {32'd0, paddr}, 64'h60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB3 requester that turns single valid/ready transaction requests from the on-chip interconnect into APB SETUP/ACCESS transfers.
- Its APB outputs drive the APB slave stage directly.
- Registers each request, sequences psel/penable, and waits on pready with a bounded timeout.
- Returns completion, read data and error status to the requester.

Parameters:
- addr_width, 32, APB address width.
- data_width, 32, APB data width.
- timeout_cycles, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- i_clk_apb  input  1  APB clock.
- i_rstn_apb  input  1  reset, asynchronous, active-low.
- i_valid  input  1  request valid.
- o_ready  output  1  master can accept a request.
- i_addr  input  addr_width  request address.
- i_rd0_wr1  input  1  request direction: 0 read, 1 write.
- i_wr_data  input  data_width  write data.
- o_done  output  1  one-cycle completion pulse, any transfer.
- o_rd_valid  output  1  one-cycle pulse, read completed (with or without error).
- o_rd_data  output  data_width  read data.
- o_err  output  1  status of the completed transfer: pslverr or timeout; valid while o_done=1.
- o_timeout  output  1  one-cycle pulse, transfer aborted by timeout.
- o_psel  output  1  APB select.
- o_penable  output  1  APB enable.
- o_pwrite  output  1  APB direction.
- o_paddr  output  addr_width  APB address.
- o_pwdata  output  data_width  APB write data.
- i_prdata  input  data_width  APB read data.
- i_pready  input  1  APB ready.
- i_pslverr  input  1  APB slave error.

Behaviour:
- All outputs are registered.
- Reset values (asynchronous, immediate, including mid-transfer): every output 0; FSM in IDLE; timeout counter 0. No o_done is issued for an interrupted transfer.
- FSM states:
  - IDLE: o_ready=1 from the first clock edge after reset release onward.
  - SETUP: o_psel=1, o_penable=0, exactly one cycle.
  - ACCESS: o_psel=1, o_penable=1, until completion.
- Accept: on an edge with i_valid=1 and o_ready=1:
  - o_paddr←i_addr, o_pwrite←i_rd0_wr1, o_pwdata←i_wr_data.
  - o_psel←1, o_ready←0, go to SETUP.
  - i_valid with o_ready=0 is ignored; the requester holds it.
- SETUP→ACCESS unconditionally on the next edge; o_penable←1; counter←0.
- In ACCESS, i_pready, i_pslverr and i_prdata are sampled only on edges where i_pready=1.
- Normal completion (i_pready=1 in ACCESS):
  - o_psel←0, o_penable←0, go to IDLE, o_ready←1.
  - o_done←1, o_err←i_pslverr.
  - If read: o_rd_valid←1, o_rd_data←i_prdata.
- Wait (i_pready=0 in ACCESS): hold all APB outputs stable; counter increments.
- Timeout (timeout_cycles≠0; i_pready=0 on the timeout_cycles-th ACCESS edge):
  - Same exit as normal completion, with o_err←1, o_timeout←1.
  - If read: o_rd_valid←1, o_rd_data←0.
- Simultaneous pready=1 and timeout edge: pready wins; normal completion, o_timeout=0.
- Pulse widths: o_done, o_rd_valid and o_timeout are high for exactly one cycle. o_err is cleared whenever o_done=0.
- Held values:
  - o_rd_data holds until the next read completion.
  - o_paddr, o_pwrite and o_pwdata hold their last values in IDLE.
  - psel=0 in IDLE.
- Latency: accept edge N → SETUP in cycle N, ACCESS in cycle N+1 → zero-wait done pulse in cycle N+2.
- Throughput: o_ready is high in the same cycle as o_done, so the next request is accepted on that edge. Minimum 3 cycles per transfer.
- Protocol invariant: penable=1 only when psel=1, and only in the cycle after a SETUP cycle.
- Counter width: $clog2(timeout_cycles+1); no wrap, because the counter is cleared on entering ACCESS.

Test Plan:
- Zero-wait write: addr 0x0000_0010, data 0xDEAD_BEEF, pready=1 → psel 1 for 2 cycles, penable high 1 cycle, pwdata=0xDEAD_BEEF; o_done=1, o_err=0, o_rd_valid=0; o_ready high with done.
- Read with 2 wait states: addr 0x24, pready low for 2 ACCESS cycles, then 1 with prdata=0x1234_5678 → ACCESS lasts 3 cycles; o_rd_valid=1, o_rd_data=0x1234_5678; APB outputs stable throughout.
- Slave error on write: pready=1, pslverr=1 → o_done=1, o_err=1, o_timeout=0. Next cycle o_err=0.
- Timeout: timeout_cycles=4, read, pready held 0 → abort after 4 ACCESS cycles; o_done=o_err=o_timeout=o_rd_valid=1, o_rd_data=0, psel=0. pready=1 exactly on the 4th edge → normal completion instead.
- Back-to-back: i_valid held with write 0x4 then read 0x8, both zero-wait → second SETUP begins in the cycle after the first done pulse; 6 cycles total; two o_done pulses.
- Reset mid-ACCESS: assert i_rstn_apb low while penable=1 → all outputs 0 immediately, no o_done. After release, o_ready=1 one edge later and a new write completes normally.
